ysyx_25060170_ifu: RTL and testbench

- Multi-cycle instruction fetch unit. It is the consumer of the execute/writeback redirect path: it takes the retire pulse and jump target produced downstream.
- Owns the PC, fetches one instruction at a time over an AXI-lite-style read channel, and hands the instruction to IDU with valid/ready.
- Waits for retire, then advances to PC+4 or to the redirect target. Bad targets, bus errors and hangs are trapped as sticky faults.

---
 rtl/ysyx_25060170_ifu.sv | 164 ++++++++++++++++
 tb/tb_ysyx_25060170_ifu.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25060170_ifu.sv
// Multi-cycle instruction fetch unit: owns the PC, fetches over an AXI-lite read
// channel, hands the word to IDU, then waits for retire to advance or redirect.
module ysyx_25060170_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        clock,
    input  logic        reset,

    output logic        imem_arvalid,
    input  logic        imem_arready,
    output logic [31:0] imem_araddr,
    input  logic        imem_rvalid,
    output logic        imem_rready,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  imem_rresp,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,

    input  logic        wb_done,
    input  logic        wb_redirect,
    input  logic [31:0] wb_target,

    output logic        ifu_fault,
    output logic [1:0]  fault_cause,
    output logic [31:0] fault_pc,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_AR,
        S_R,
        S_DISP,
        S_EXEC,
        S_FAULT
    } state_e;

    localparam logic [1:0]  CAUSE_MISALIGN = 2'd1;
    localparam logic [1:0]  CAUSE_BUS      = 2'd2;
    localparam logic [1:0]  CAUSE_TIMEOUT  = 2'd3;
    localparam logic [15:0] TIMEOUT_LIM    = 16'(TIMEOUT);

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic [15:0] tmo_cnt_q;
    logic        fault_q;
    logic [1:0]  fault_cause_q;
    logic [31:0] fault_pc_q;

    logic        in_bus;
    logic [15:0] tmo_cnt_d;
    logic        tmo_hit;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        in_bus    = 1'b0;
        tmo_cnt_d = tmo_cnt_q + 16'd1;
        tmo_hit   = 1'b0;
        if (state_q == S_AR || state_q == S_R) begin
            in_bus  = 1'b1;
            tmo_hit = (tmo_cnt_d == TIMEOUT_LIM);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_AR;
            pc_q          <= RESET_PC;
            inst_q        <= '0;
            inst_pc_q     <= '0;
            tmo_cnt_q     <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= '0;
            fault_pc_q    <= '0;
        end else begin
            if (in_bus) begin
                tmo_cnt_q <= tmo_cnt_d;
            end

            unique case (state_q)
                S_AR: begin
                    if (tmo_hit) begin
                        state_q       <= S_FAULT;
                        fault_q       <= 1'b1;
                        fault_cause_q <= CAUSE_TIMEOUT;
                        fault_pc_q    <= pc_q;
                    end else if (imem_arready) begin
                        state_q <= S_R;
                    end
                end

                // A response in the same cycle the counter expires still wins.
                S_R: begin
                    if (imem_rvalid) begin
                        if (imem_rresp == 2'b00) begin
                            state_q   <= S_DISP;
                            inst_q    <= imem_rdata;
                            inst_pc_q <= pc_q;
                        end else begin
                            state_q       <= S_FAULT;
                            fault_q       <= 1'b1;
                            fault_cause_q <= CAUSE_BUS;
                            fault_pc_q    <= pc_q;
                        end
                    end else if (tmo_hit) begin
                        state_q       <= S_FAULT;
                        fault_q       <= 1'b1;
                        fault_cause_q <= CAUSE_TIMEOUT;
                        fault_pc_q    <= pc_q;
                    end
                end

                S_DISP: begin
                    if (inst_ready) begin
                        state_q <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (wb_done) begin
                        if (wb_redirect && wb_target[1:0] != 2'b00) begin
                            state_q       <= S_FAULT;
                            fault_q       <= 1'b1;
                            fault_cause_q <= CAUSE_MISALIGN;
                            fault_pc_q    <= wb_target;
                        end else begin
                            state_q   <= S_AR;
                            tmo_cnt_q <= '0;
                            pc_q      <= wb_redirect ? wb_target : pc_q + 32'd4;
                        end
                    end
                end

                S_FAULT: begin
                    state_q <= S_FAULT;
                end

                default: begin
                    state_q <= S_FAULT;
                end
            endcase
        end
    end

    // Handshakes are forced low while reset is held so nothing leaks before the first fetch.
    assign imem_arvalid = !reset && (state_q == S_AR);
    assign imem_rready  = !reset && (state_q == S_R);
    assign inst_valid   = !reset && (state_q == S_DISP);
    assign imem_araddr  = pc_q;

    assign inst         = inst_q;
    assign inst_pc      = inst_pc_q;
    assign ifu_fault    = fault_q;
    assign fault_cause  = fault_cause_q;
    assign fault_pc     = fault_pc_q;
    assign busy         = (state_q != S_EXEC) && (state_q != S_FAULT);

endmodule

// File: tb/tb_ysyx_25060170_ifu.sv
// Directed bench for ysyx_25060170_ifu: fetch sequencing, backpressure, redirect,
// PC wrap, the three fault causes, timeout boundary and reset mid-transaction.
module tb_ysyx_25060170_ifu;

    logic        clock;
    logic        reset;
    logic        imem_arvalid;
    logic        imem_arready;
    logic [31:0] imem_araddr;
    logic        imem_rvalid;
    logic        imem_rready;
    logic [31:0] imem_rdata;
    logic [1:0]  imem_rresp;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        wb_done;
    logic        wb_redirect;
    logic [31:0] wb_target;
    logic        ifu_fault;
    logic [1:0]  fault_cause;
    logic [31:0] fault_pc;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    ysyx_25060170_ifu #(
        .RESET_PC (32'h8000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .imem_arvalid (imem_arvalid),
        .imem_arready (imem_arready),
        .imem_araddr  (imem_araddr),
        .imem_rvalid  (imem_rvalid),
        .imem_rready  (imem_rready),
        .imem_rdata   (imem_rdata),
        .imem_rresp   (imem_rresp),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .wb_done      (wb_done),
        .wb_redirect  (wb_redirect),
        .wb_target    (wb_target),
        .ifu_fault    (ifu_fault),
        .fault_cause  (fault_cause),
        .fault_pc     (fault_pc),
        .busy         (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        imem_rresp   = '0;
        inst_ready   = 1'b0;
        wb_done      = 1'b0;
        wb_redirect  = 1'b0;
        wb_target    = '0;
        tick();
        tick();
        check("rst_arvalid", imem_arvalid, 0);
        check("rst_rready", imem_rready, 0);
        check("rst_inst_valid", inst_valid, 0);
        reset = 1'b0;
        #1;
    endtask

    // Expects to be in S_AR; completes a clean fetch and leaves the unit in S_DISP.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data,
                         input int ar_wait, input int r_wait);
        check("ar_valid", imem_arvalid, 1);
        check("ar_addr", imem_araddr, addr);
        for (int i = 0; i < ar_wait; i++) begin
            tick();
            check("ar_hold", {imem_arvalid, imem_rready}, 2'b10);
            check("ar_addr_hold", imem_araddr, addr);
        end
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        check("r_phase", {imem_arvalid, imem_rready}, 2'b01);
        for (int i = 0; i < r_wait; i++) tick();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        imem_rresp  = 2'b00;
        tick();
        imem_rvalid = 1'b0;
        check("disp_valid", inst_valid, 1);
        check("disp_inst", inst, data);
        check("disp_pc", inst_pc, addr);
    endtask

    task automatic accept();
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("exec_idle", {inst_valid, imem_arvalid, busy}, 3'b000);
    endtask

    task automatic retire(input logic redirect, input logic [31:0] target);
        wb_done     = 1'b1;
        wb_redirect = redirect;
        wb_target   = target;
        tick();
        wb_done     = 1'b0;
        wb_redirect = 1'b0;
    endtask

    int n_ar;

    initial begin
        // Reset values and sequential fetch of three addi x0,x0,0
        do_reset();
        check("rst_inst", inst, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_fault", {ifu_fault, fault_cause}, 3'b000);
        check("rst_fault_pc", fault_pc, 0);
        check("rst_busy", busy, 1);
        fetch(32'h8000_0000, 32'h0000_0013, 0, 0);
        accept();
        retire(1'b0, 32'h0);
        fetch(32'h8000_0004, 32'h0000_0013, 0, 0);
        accept();
        retire(1'b0, 32'h0);
        // Counter reaches the limit on the same cycle rvalid arrives: no fault
        fetch(32'h8000_0008, 32'h0000_0013, 1, 1);
        check("tmo_boundary_nofault", ifu_fault, 0);

        // IDU backpressure for five cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", inst_valid, 1);
            check("stall_inst", inst, 32'h0000_0013);
            check("stall_pc", inst_pc, 32'h8000_0008);
        end
        accept();
        retire(1'b1, 32'h8000_0100);
        fetch(32'h8000_0100, 32'h0010_0073, 0, 0);
        accept();

        // Redirect to the last word, retire in S_DISP ignored, then wrap to 0
        retire(1'b1, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0000_006F, 0, 0);
        retire(1'b1, 32'h1234_5678);
        check("wb_in_disp_ignored", inst_valid, 1);
        check("wb_in_disp_pc", imem_araddr, 32'hFFFF_FFFC);
        accept();
        wb_redirect = 1'b1;
        wb_target   = 32'h0000_0040;
        tick();
        wb_redirect = 1'b0;
        check("redirect_no_done", {imem_arvalid, busy}, 2'b00);
        retire(1'b0, 32'h0);
        check("wrap_addr", imem_araddr, 32'h0000_0000);
        check("wrap_arvalid", imem_arvalid, 1);

        // Bus error on the fetch at 0x80000004
        do_reset();
        fetch(32'h8000_0000, 32'h0000_0013, 0, 0);
        accept();
        retire(1'b0, 32'h0);
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        imem_rvalid  = 1'b1;
        imem_rresp   = 2'b10;
        imem_rdata   = 32'hBAD0_BAD0;
        tick();
        imem_rvalid  = 1'b0;
        imem_rresp   = 2'b00;
        check("bus_fault", {ifu_fault, fault_cause}, 3'b110);
        check("bus_fault_pc", fault_pc, 32'h8000_0004);
        for (int i = 0; i < 4; i++) begin
            imem_arready = 1'b1;
            imem_rvalid  = 1'b1;
            inst_ready   = 1'b1;
            tick();
            check("bus_frozen", {inst_valid, imem_arvalid, imem_rready, busy}, 4'b0000);
        end
        imem_arready = 1'b0;
        imem_rvalid  = 1'b0;
        inst_ready   = 1'b0;
        check("bus_frozen_pc", fault_pc, 32'h8000_0004);
        check("bus_inst_kept", inst, 32'h0000_0013);

        // Misaligned redirect target
        do_reset();
        fetch(32'h8000_0000, 32'h0000_0013, 0, 0);
        accept();
        retire(1'b1, 32'h8000_0102);
        check("mis_fault", {ifu_fault, fault_cause}, 3'b101);
        check("mis_fault_pc", fault_pc, 32'h8000_0102);
        check("mis_pc_kept", imem_araddr, 32'h8000_0000);
        for (int i = 0; i < 4; i++) begin
            retire(1'b1, 32'h8000_0200);
            check("mis_no_arvalid", imem_arvalid, 0);
        end
        check("mis_frozen", fault_pc, 32'h8000_0102);

        // Timeout in AR: exactly four cycles of arvalid
        do_reset();
        n_ar = 0;
        for (int i = 0; i < 12 && !ifu_fault; i++) begin
            if (imem_arvalid) n_ar++;
            tick();
        end
        check("tmo_ar_cycles", n_ar, 4);
        check("tmo_ar_fault", {ifu_fault, fault_cause}, 3'b111);
        check("tmo_ar_pc", fault_pc, 32'h8000_0000);

        // Timeout in R: one AR cycle then three R cycles without data
        do_reset();
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        tick();
        tick();
        check("tmo_r_pending", {ifu_fault, imem_rready}, 2'b01);
        tick();
        check("tmo_r_fault", {ifu_fault, fault_cause}, 3'b111);

        // Reset during S_R, stale rvalid right after reset is ignored
        do_reset();
        imem_arready = 1'b1;
        tick();
        imem_arready = 1'b0;
        check("midrst_in_r", imem_rready, 1);
        reset = 1'b1;
        #1;
        check("midrst_rready_low", imem_rready, 0);
        tick();
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        check("stale_rready", {imem_arvalid, imem_rready}, 2'b10);
        tick();
        imem_rvalid = 1'b0;
        check("stale_ignored", {inst_valid, imem_arvalid, ifu_fault}, 3'b010);
        fetch(32'h8000_0000, 32'h0000_0093, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
